// File: rtl/dram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dram_responder: line-organised backing store with an in-order command    |
// | queue and fixed-latency tagged read bursts. DRAM_PROTOCOL_CHECK_EN       |
// | builds the sticky proto_err checker. Revision 1.0                        |
// +--------------------------------------------------------------------------+

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module dram_responder #(
  parameter int LATENCY     = 8,
  parameter int DEPTH_LOG2  = 10,
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_req_valid,
  output logic                          mem_req_ready,
  input  logic                          mem_req_rw,
  input  logic [`MEM_ADDR_BITS-1:0]     mem_req_addr,
  input  logic [`MEM_TAG_BITS-1:0]      mem_req_tag,
  input  logic                          mem_req_data_valid,
  output logic                          mem_req_data_ready,
  input  logic [`MEM_DATA_BITS-1:0]     mem_req_data_bits,
  input  logic [`MEM_DATA_BITS/8-1:0]   mem_req_data_mask,
  input  logic [1:0]                    mem_req_data_offset,
  output logic                          mem_resp_valid,
  output logic [`MEM_TAG_BITS-1:0]      mem_resp_tag,
  output logic [`MEM_DATA_BITS-1:0]     mem_resp_data,
  output logic                          proto_err
);

  localparam int c_addr_bits = `MEM_ADDR_BITS;
  localparam int c_tag_bits  = `MEM_TAG_BITS;
  localparam int c_data_bits = `MEM_DATA_BITS;
  localparam int c_mask_bits = c_data_bits / 8;
  localparam int c_qdepth    = 1 << QDEPTH_LOG2;
  localparam int c_ent_bits  = 1 + DEPTH_LOG2 + c_tag_bits;
  localparam int c_words     = 1 << (DEPTH_LOG2 + 2);
  localparam logic [7:0]           c_cnt_init = 8'(LATENCY - 2);
  localparam logic [QDEPTH_LOG2:0] c_qinc     = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_WDATA = 2'd3
  } state_t;

  // ---------------- command queue ----------------
  logic [c_ent_bits-1:0]   r_q [c_qdepth];
  logic [QDEPTH_LOG2:0]    r_wptr;
  logic [QDEPTH_LOG2:0]    r_rptr;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_head_rw;
  logic [DEPTH_LOG2-1:0]   w_head_line;
  logic [c_tag_bits-1:0]   w_head_tag;

  assign w_full  = (r_wptr[QDEPTH_LOG2] != r_rptr[QDEPTH_LOG2]) &&
                   (r_wptr[QDEPTH_LOG2-1:0] == r_rptr[QDEPTH_LOG2-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  // No bypass: a full queue stays not-ready even in a popping cycle.
  assign mem_req_ready = reset & ~w_full;
  assign w_push        = mem_req_valid & mem_req_ready;
  assign {w_head_rw, w_head_line, w_head_tag} = r_q[r_rptr[QDEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q[r_wptr[QDEPTH_LOG2-1:0]] <= {mem_req_rw, mem_req_addr[DEPTH_LOG2-1:0], mem_req_tag};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_qinc;
      if (w_pop)  r_rptr <= r_rptr + c_qinc;
    end
  end

  // ---------------- engine ----------------
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [7:0]              r_cnt;
  logic [7:0]              w_cnt_nxt;
  logic [1:0]              r_beat;
  logic [1:0]              w_beat_nxt;
  logic [c_tag_bits-1:0]   r_tag;
  logic [c_tag_bits-1:0]   w_tag_nxt;
  logic [DEPTH_LOG2-1:0]   r_line;
  logic [DEPTH_LOG2-1:0]   w_line_nxt;
  logic [c_data_bits-1:0]  r_mem [c_words];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_tag   <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_beat  <= w_beat_nxt;
      r_tag   <= w_tag_nxt;
      r_line  <= w_line_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_beat_nxt         = r_beat;
    w_tag_nxt          = r_tag;
    w_line_nxt         = r_line;
    w_pop              = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_tag       = '0;
    mem_resp_data      = '0;
    mem_req_data_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_tag_nxt  = w_head_tag;
          w_line_nxt = w_head_line;
          w_beat_nxt = 2'd0;
          if (w_head_rw) begin
            w_state_nxt = S_WDATA;
          end else if (LATENCY == 2) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_cnt_init;
          end
        end
      end
      S_WAIT: begin
        // Leaving as the count reaches zero puts beat 0 at S+LATENCY-1.
        if (r_cnt <= 8'd1) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_RESP: begin
        mem_resp_valid = 1'b1;
        mem_resp_tag   = r_tag;
        mem_resp_data  = r_mem[{r_line, r_beat}];
        w_beat_nxt     = r_beat + 2'd1;
        if (r_beat == 2'd3) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WDATA: begin
        mem_req_data_ready = 1'b1;
        if (mem_req_data_valid) begin
          w_beat_nxt = r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            w_pop       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage is deliberately not reset; byte-masked writes land at the beat offset.
  always_ff @(posedge clk) begin
    if (r_state == S_WDATA && mem_req_data_valid) begin
      for (int b = 0; b < c_mask_bits; b++) begin
        if (mem_req_data_mask[b]) begin
          r_mem[{r_line, mem_req_data_offset}][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
        end
      end
    end
  end

`ifdef DRAM_PROTOCOL_CHECK_EN
  logic r_proto_err;
  logic w_proto_viol;

  assign w_proto_viol =
      (mem_req_data_valid && r_state != S_WDATA) ||
      (mem_req_data_valid && r_state == S_WDATA && mem_req_data_offset != r_beat) ||
      (mem_req_valid && mem_req_addr[c_addr_bits-1:DEPTH_LOG2] != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_proto_err <= 1'b0;
    else        r_proto_err <= r_proto_err | w_proto_viol;
  end

  assign proto_err = r_proto_err;
`else
  logic w_unused;
  assign w_unused  = ^mem_req_addr[c_addr_bits-1:DEPTH_LOG2];
  assign proto_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/dram_responder.md
# dram_responder

Memory-side responder for the processor's external memory port: it accepts line requests and write-data beats from the memory subsystem and returns tagged read data after a fixed latency. It sits at the opposite end of the mem_req / mem_req_data / mem_resp interface from the cache controller. It serves as the synthesizable backing store for simulation and FPGA bring-up. Storage is a line-organised array of four MEM_DATA_BITS beats per line, with in-order command processing.

## Interface
Widths `MEM_ADDR_BITS, `MEM_TAG_BITS and `MEM_DATA_BITS come from the shared memory-interface defines.

Parameters:
- LATENCY, 8, cycles from read acceptance (idle engine) to first response beat; legal range 2..255.
- DEPTH_LOG2, 10, log2 of the number of lines stored; the line index is mem_req_addr[DEPTH_LOG2-1:0].
- QDEPTH_LOG2, 2, log2 of the command-queue depth (default 4 entries).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- mem_req_valid  input  1  command valid.
- mem_req_ready  output  1  command queue not full.
- mem_req_rw  input  1  1 = write, 0 = read.
- mem_req_addr  input  `MEM_ADDR_BITS  line address.
- mem_req_tag  input  `MEM_TAG_BITS  request tag, echoed on reads.
- mem_req_data_valid  input  1  write beat valid.
- mem_req_data_ready  output  1  write beat accepted when high together with valid.
- mem_req_data_bits  input  `MEM_DATA_BITS  write beat data.
- mem_req_data_mask  input  `MEM_DATA_BITS/8  byte enables; 1 = write the byte.
- mem_req_data_offset  input  2  beat index within the line.
- mem_resp_valid  output  1  read beat valid; there is no backpressure.
- mem_resp_tag  output  `MEM_TAG_BITS  tag of the read being returned.
- mem_resp_data  output  `MEM_DATA_BITS  read beat data, beat 0 first.
- proto_err  output  1  sticky protocol error flag; see Configuration.

## Operation
- **Command queue.** Synchronous FIFO of {rw, addr, tag}.
  - Enqueue on mem_req_valid && mem_req_ready.
  - mem_req_ready = !full, registered-free combinational. There is no bypass: a full queue stays not-ready in a cycle that also pops.
- **Engine FSM.** States IDLE, WAIT, RESP, WDATA.
  - IDLE: if the queue is non-empty, latch the head. Read goes to WAIT with counter = LATENCY-2; write goes to WDATA. Call this cycle S.
  - WAIT: decrement the counter; at 0 go to RESP with beat = 0.
  - RESP: mem_resp_valid=1, tag = latched tag, data = line[beat]. Increment beat each cycle. After beat 3, pop the queue and return to IDLE.
  - WDATA: mem_req_data_ready=1. Each handshake writes mem_req_data_bits into line[mem_req_data_offset], per-byte under the mask, and increments the beat counter. On the 4th beat, pop the queue and return to IDLE.
- Commands complete strictly in order. A read following a write to the same line returns the written data.
- Outputs in non-RESP states: mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=0.
- **Reset.** Asserting reset, including mid-burst, empties the queue and forces IDLE, all counters to 0, all outputs to 0, and proto_err to 0. A truncated burst is not completed. Storage contents are not reset.

## Timing
- Read accepted at cycle T into an empty queue with an idle engine: S = T+1, beats at T+LATENCY .. T+LATENCY+3 on consecutive cycles.
- In general, the first read beat arrives at S+LATENCY-1 and the last at S+LATENCY+2. The next command's S is no earlier than the cycle after the last beat or write data beat.
- Write accepted at T into an idle engine: mem_req_data_ready is high from T+2. With continuous valid, the four beats are accepted at T+2..T+5, and the written data is visible to a read whose S is T+6 or later.
- Storage read is combinational from the array, or registered one cycle ahead; either way mem_resp_data must meet the beat timing above.

## Configuration
- DRAM_PROTOCOL_CHECK_EN defined: proto_err is set one cycle after any of the following, and held until reset:
  - mem_req_data_valid high outside WDATA;
  - mem_req_data_offset differing from the internal beat count during a WDATA handshake;
  - mem_req_valid with mem_req_addr bits above DEPTH_LOG2 non-zero.
- DRAM_PROTOCOL_CHECK_EN undefined: proto_err is tied to 0 and no check logic is built.

## Test plan
- Single read: LATENCY=8, read of line 5 with tag 3 at T=10 -> mem_resp_valid at cycles 18..21, tag 3, the four beats of line 5 in order.
- Write then read: write line 7 with tag 1, beats 0..3 = 0x11.., 0x22.., 0x33.., 0x44.., full mask; then read line 7 with tag 2 -> response carries the same four beats with tag 2, and no response is produced for the write.
- Byte mask: write 0xFF..FF to line 9 beat 1 with mask 0x0001 over a line that was all zeros -> read returns beat 1 = 0x..00FF, and the other beats are unchanged.
- Queue full: 5 back-to-back reads with an idle engine -> mem_req_ready drops after the 4th enqueue and returns high the cycle after the first pop. All 5 tags come back in order with no gaps between beat groups other than LATENCY-1 cycles.
- Reset mid-burst: assert reset during RESP beat 1 -> mem_resp_valid is 0 immediately. After release, queue empty, mem_req_ready=1, and no stale beats appear.
- Protocol check (with DRAM_PROTOCOL_CHECK_EN): pulse mem_req_data_valid while IDLE -> proto_err=1 the next cycle and it stays 1 until reset.
